// File: rtl/dm_sram_slave_if.sv
// AXI4 slave-side channel bundle between the data-side interconnect and dm_sram_slave.
interface dm_sram_slave_if #(
    parameter int unsigned ID_W  = 8,
    parameter int unsigned LEN_W = 4
);
    logic [ID_W-1:0]  AWID_S;
    logic [31:0]      AWADDR_S;
    logic [LEN_W-1:0] AWLEN_S;
    logic [2:0]       AWSIZE_S;
    logic [1:0]       AWBURST_S;
    logic             AWVALID_S;
    logic             AWREADY_S;
    logic [31:0]      WDATA_S;
    logic [3:0]       WSTRB_S;
    logic             WLAST_S;
    logic             WVALID_S;
    logic             WREADY_S;
    logic [ID_W-1:0]  BID_S;
    logic [1:0]       BRESP_S;
    logic             BVALID_S;
    logic             BREADY_S;
    logic [ID_W-1:0]  ARID_S;
    logic [31:0]      ARADDR_S;
    logic [LEN_W-1:0] ARLEN_S;
    logic [2:0]       ARSIZE_S;
    logic [1:0]       ARBURST_S;
    logic             ARVALID_S;
    logic             ARREADY_S;
    logic [ID_W-1:0]  RID_S;
    logic [31:0]      RDATA_S;
    logic [1:0]       RRESP_S;
    logic             RLAST_S;
    logic             RVALID_S;
    logic             RREADY_S;

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S
    );

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S
    );
endinterface

// File: rtl/dm_sram_slave.sv
// AXI4 slave front-end for the single-port data-memory SRAM; one transaction at a time.
// Optional out-of-range DECERR checking is enabled by defining DM_SRAM_SLAVE_RANGE_CHK_EN.
module dm_sram_slave #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    dm_sram_slave_if.slave    axi,
    output logic              CEB,
    output logic              WEB,
    output logic [31:0]       BWEB,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       DI,
    input  logic [31:0]       DO
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RFETCH = 3'd1,
        S_RDATA  = 3'd2,
        S_WDATA  = 3'd3,
        S_WRESP  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ID_W-1:0]  r_id;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_werr;

    logic w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_b_hs;
    logic w_last, w_w_end, w_oor;

    assign w_ar_hs = axi.ARVALID_S & axi.ARREADY_S;
    assign w_aw_hs = axi.AWVALID_S & axi.AWREADY_S;
    assign w_r_hs  = axi.RVALID_S  & axi.RREADY_S;
    assign w_w_hs  = axi.WVALID_S  & axi.WREADY_S;
    assign w_b_hs  = axi.BVALID_S  & axi.BREADY_S;
    assign w_last  = (r_cnt == r_len);
    assign w_w_end = axi.WLAST_S | w_last;

`ifdef DM_SRAM_SLAVE_RANGE_CHK_EN
    assign w_oor = (r_addr[31:ADDR_W+2] != '0);
`else
    assign w_oor = 1'b0;
`endif

    // Size/burst type are always executed as 32-bit INCR; low address bits are ignored.
    logic w_unused;
    assign w_unused = ^{axi.ARSIZE_S, axi.ARBURST_S, axi.AWSIZE_S, axi.AWBURST_S,
                        r_addr[31:ADDR_W+2], r_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs)      w_next = S_RFETCH;
                else if (w_aw_hs) w_next = S_WDATA;
            end
            S_RFETCH: w_next = S_RDATA;
            S_RDATA:  if (w_r_hs) w_next = w_last ? S_IDLE : S_RFETCH;
            S_WDATA:  if (w_w_hs && w_w_end) w_next = S_WRESP;
            S_WRESP:  if (w_b_hs) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Transaction latches and beat address/counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_id   <= '0;
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_werr <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_id   <= axi.ARID_S;
                r_addr <= axi.ARADDR_S;
                r_len  <= axi.ARLEN_S;
                r_cnt  <= '0;
                r_werr <= 1'b0;
            end else if (w_aw_hs) begin
                r_id   <= axi.AWID_S;
                r_addr <= axi.AWADDR_S;
                r_len  <= axi.AWLEN_S;
                r_cnt  <= '0;
                r_werr <= 1'b0;
            end else if ((w_r_hs && !w_last) || (w_w_hs && !w_w_end)) begin
                r_addr <= r_addr + 32'd4;
                r_cnt  <= r_cnt + LEN_W'(1);
            end
            if (w_w_hs && w_oor) r_werr <= 1'b1;
        end
    end

    // Bus and SRAM strobes; everything is held quiet while reset is asserted
    always_comb begin
        axi.ARREADY_S = 1'b0;
        axi.AWREADY_S = 1'b0;
        axi.WREADY_S  = 1'b0;
        axi.RVALID_S  = 1'b0;
        axi.RID_S     = r_id;
        axi.RDATA_S   = '0;
        axi.RRESP_S   = 2'b00;
        axi.RLAST_S   = 1'b0;
        axi.BVALID_S  = 1'b0;
        axi.BID_S     = r_id;
        axi.BRESP_S   = r_werr ? 2'b11 : 2'b00;
        CEB           = 1'b1;
        WEB           = 1'b1;
        BWEB          = '1;
        A             = r_addr[ADDR_W+1:2];
        DI            = axi.WDATA_S;
        if (rstn) begin
            case (r_state)
                S_IDLE: begin
                    axi.ARREADY_S = 1'b1;
                    axi.AWREADY_S = ~axi.ARVALID_S;
                end
                S_RFETCH: CEB = w_oor;
                S_RDATA: begin
                    axi.RVALID_S = 1'b1;
                    axi.RLAST_S  = w_last;
                    if (w_oor) axi.RRESP_S = 2'b11;
                    else       axi.RDATA_S = DO;
                end
                S_WDATA: begin
                    axi.WREADY_S = 1'b1;
                    if (axi.WVALID_S && !w_oor) begin
                        CEB = 1'b0;
                        WEB = 1'b0;
                        for (int i = 0; i < 4; i++) BWEB[8*i +: 8] = {8{~axi.WSTRB_S[i]}};
                    end
                end
                S_WRESP: axi.BVALID_S = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_sram_slave.sv
// Self-checking bench for dm_sram_slave: SRAM macro model plus a word-array reference memory.
module tb_dm_sram_slave;
    localparam int unsigned NWORDS = 16384;
`ifdef DM_SRAM_SLAVE_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        CEB, WEB;
    logic [31:0] BWEB, DI, sram_do;
    logic [13:0] A;

    logic [31:0] sram    [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    logic        fill_en = 1'b0;
    logic        pl_en   = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];

    int n_assert = 0;
    int n_fail   = 0;

    dm_sram_slave_if #(.ID_W(8), .LEN_W(4)) axi ();

    dm_sram_slave #(.ADDR_W(14), .ID_W(8), .LEN_W(4)) dut (
        .clk (clk), .rstn(rstn), .axi(axi),
        .CEB (CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(sram_do)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fill_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Single-port SRAM macro: 1-cycle read, bit-masked write, DO held when idle
    always @(posedge clk) begin
        if (CEB == 1'b0) begin
            if (WEB == 1'b0) sram[A] <= (sram[A] & BWEB) | (DI & ~BWEB);
            else             sram_do <= sram[A];
        end else if (fill_en) begin
            for (int i = 0; i < NWORDS; i++) sram[i] <= fill_val(i);
        end else if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        logic [31:0] m;
        m = '1;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'h00;
        return m;
    endfunction

    function automatic bit out_of_range(input logic [31:0] ba);
        return RCHK && (ba >= 32'h0001_0000);
    endfunction

    task automatic preload(input logic [13:0] w, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = w; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [7:0] id,
                            input int stall_beat, input int stall_cyc);
        logic [31:0] ba, exp_d;
        bit          oor;
        axi.ARVALID_S = 1'b1; axi.ARADDR_S = addr; axi.ARLEN_S = 4'(len); axi.ARID_S = id;
        axi.ARSIZE_S = 3'($urandom_range(7)); axi.ARBURST_S = 2'($urandom_range(3));
        #1;
        check("arready", 32'(axi.ARREADY_S), 1);
        check("awready_blocked", 32'(axi.AWREADY_S), 0);
        @(posedge clk); #1;
        axi.ARVALID_S = 1'b0;
        for (int b = 0; b <= len; b++) begin
            ba  = addr + 32'(4 * b);
            oor = out_of_range(ba);
            check("ceb_rfetch", 32'(CEB), 32'(oor));
            if (!oor) check("a_rfetch", 32'(A), 32'(ba[15:2]));
            check("rvalid_rfetch", 32'(axi.RVALID_S), 0);
            check("awready_busy", 32'(axi.AWREADY_S), 0);
            @(posedge clk); #1;
            exp_d = oor ? 32'h0 : ref_mem[ba[15:2]];
            check("rvalid", 32'(axi.RVALID_S), 1);
            check("rdata", axi.RDATA_S, exp_d);
            check("rid", 32'(axi.RID_S), 32'(id));
            check("rlast", 32'(axi.RLAST_S), 32'(b == len));
            check("rresp", 32'(axi.RRESP_S), oor ? 32'd3 : 32'd0);
            if (b == stall_beat) begin
                repeat (stall_cyc) begin
                    @(posedge clk); #1;
                    check("r_hold_valid", 32'(axi.RVALID_S), 1);
                    check("r_hold_data", axi.RDATA_S, exp_d);
                    check("r_hold_ceb", 32'(CEB), 1);
                end
            end
            axi.RREADY_S = 1'b1;
            @(posedge clk); #1;
            axi.RREADY_S = 1'b0;
        end
        #1;
        check("idle_after_read", 32'(axi.ARREADY_S), 1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [7:0] id,
                             input int wlast_beat, input int nsend, input int bstall);
        int          e;
        logic [31:0] ba;
        logic [13:0] w;
        bit          oor, anyerr;
        e = (wlast_beat < len) ? wlast_beat : len;
        anyerr = 1'b0;
        axi.AWVALID_S = 1'b1; axi.AWADDR_S = addr; axi.AWLEN_S = 4'(len); axi.AWID_S = id;
        axi.AWSIZE_S = 3'($urandom_range(7)); axi.AWBURST_S = 2'($urandom_range(3));
        #1;
        check("awready", 32'(axi.AWREADY_S), 1);
        @(posedge clk); #1;
        axi.AWVALID_S = 1'b0;
        for (int b = 0; b <= e && b < nsend; b++) begin
            if ($urandom_range(3) == 0) begin
                axi.WVALID_S = 1'b0;
                #1;
                check("ceb_wgap", 32'(CEB), 1);
                @(posedge clk); #1;
            end
            ba  = addr + 32'(4 * b);
            w   = ba[15:2];
            oor = out_of_range(ba);
            axi.WVALID_S = 1'b1; axi.WDATA_S = wdat[b]; axi.WSTRB_S = wstb[b];
            axi.WLAST_S = (b == wlast_beat);
            #1;
            check("wready", 32'(axi.WREADY_S), 1);
            check("ceb_w", 32'(CEB), 32'(oor));
            if (!oor) begin
                check("web_w", 32'(WEB), 0);
                check("a_w", 32'(A), 32'(w));
                check("di_w", DI, wdat[b]);
                check("bweb_w", BWEB, mask_of(wstb[b]));
                for (int i = 0; i < 4; i++)
                    if (wstb[b][i]) ref_mem[w][8*i +: 8] = wdat[b][8*i +: 8];
            end else begin
                anyerr = 1'b1;
            end
            @(posedge clk); #1;
        end
        axi.WVALID_S = 1'b0; axi.WLAST_S = 1'b0;
        #1;
        if (nsend > e) begin
            check("bvalid", 32'(axi.BVALID_S), 1);
            check("bid", 32'(axi.BID_S), 32'(id));
            check("bresp", 32'(axi.BRESP_S), anyerr ? 32'd3 : 32'd0);
            check("wready_in_resp", 32'(axi.WREADY_S), 0);
            repeat (bstall) begin
                @(posedge clk); #1;
                check("b_hold", 32'(axi.BVALID_S), 1);
            end
            axi.BREADY_S = 1'b1;
            @(posedge clk); #1;
            axi.BREADY_S = 1'b0;
            #1;
            check("b_done", 32'(axi.BVALID_S), 0);
            check("idle_after_write", 32'(axi.ARREADY_S), 1);
        end
    endtask

    initial begin
        int          len, wl, nbad;
        logic [31:0] addr;
        axi.AWVALID_S = 0; axi.AWID_S = '0; axi.AWADDR_S = '0; axi.AWLEN_S = '0;
        axi.AWSIZE_S = 3'b010; axi.AWBURST_S = 2'b01;
        axi.WVALID_S = 0; axi.WDATA_S = '0; axi.WSTRB_S = '0; axi.WLAST_S = 0;
        axi.BREADY_S = 0; axi.RREADY_S = 0;
        axi.ARVALID_S = 0; axi.ARID_S = '0; axi.ARADDR_S = '0; axi.ARLEN_S = '0;
        axi.ARSIZE_S = 3'b010; axi.ARBURST_S = 2'b01;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = fill_val(i);

        // Reset state
        fill_en = 1'b1;
        @(posedge clk); #1;
        fill_en = 1'b0;
        @(posedge clk); #1;
        check("rst_arready", 32'(axi.ARREADY_S), 0);
        check("rst_awready", 32'(axi.AWREADY_S), 0);
        check("rst_wready", 32'(axi.WREADY_S), 0);
        check("rst_rvalid", 32'(axi.RVALID_S), 0);
        check("rst_bvalid", 32'(axi.BVALID_S), 0);
        check("rst_ceb", 32'(CEB), 1);
        check("rst_web", 32'(WEB), 1);
        check("rst_bweb", BWEB, 32'hFFFF_FFFF);
        rstn = 1'b1;
        #1;
        check("idle_arready", 32'(axi.ARREADY_S), 1);
        check("idle_awready", 32'(axi.AWREADY_S), 1);

        // Single read
        preload(14'h10, 32'hDEAD_BEEF);
        axi_read(32'h40, 0, 8'h21, -1, 0);

        // Write with byte strobes
        preload(14'h5, 32'h1122_3344);
        wdat[0] = 32'hAABB_CCDD; wstb[0] = 4'b0101;
        axi_write(32'h14, 0, 8'h5A, 0, 1, 1);
        check("strobe_merge", sram[5], 32'h11BB_33DD);
        check("bweb_0101", mask_of(wstb[0]), 32'hFF00_FF00);

        // Burst read with backpressure on beat 1
        axi_read(32'h100, 3, 8'h33, 1, 3);

        // Simultaneous AR and AW: read first, then the pending write
        axi.AWVALID_S = 1'b1; axi.AWADDR_S = 32'h200; axi.AWLEN_S = 4'd1; axi.AWID_S = 8'h45;
        axi_read(32'h300, 1, 8'h44, -1, 0);
        wdat[0] = 32'h0102_0304; wstb[0] = 4'hF;
        wdat[1] = 32'h0506_0708; wstb[1] = 4'hF;
        axi_write(32'h200, 1, 8'h45, 1, 2, 0);

        // Reset in the middle of a 4-beat write after 2 beats
        for (int b = 0; b < 4; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
        axi_write(32'h400, 3, 8'h66, 3, 2, 0);
        axi.WVALID_S = 1'b1; axi.WDATA_S = wdat[2]; axi.WSTRB_S = 4'hF;
        rstn = 1'b0;
        #1;
        check("rst_mid_ceb", 32'(CEB), 1);
        @(posedge clk); #1;
        check("rst_mid_bvalid", 32'(axi.BVALID_S), 0);
        check("rst_mid_wready", 32'(axi.WREADY_S), 0);
        rstn = 1'b1; axi.WVALID_S = 1'b0;
        #1;
        check("rst_mid_idle", 32'(axi.ARREADY_S), 1);
        check("rst_mid_w1", sram[14'h101], wdat[1]);
        check("rst_mid_w2", sram[14'h102], fill_val(14'h102));

        // Early WLAST ends a len-5 burst after 3 beats
        for (int b = 0; b < 6; b++) begin wdat[b] = $urandom; wstb[b] = 4'($urandom_range(15)); end
        axi_write(32'h500, 5, 8'h77, 2, 16, 0);
        check("early_wlast_untouched", sram[14'h143], fill_val(14'h143));

        // Word-address wrap at the top of the array
        for (int b = 0; b < 4; b++) begin wdat[b] = $urandom; wstb[b] = 4'hF; end
        axi_write(32'hFFF8, 3, 8'h88, 3, 16, 2);
        axi_read(32'hFFF8, 3, 8'h89, 2, 1);

        // Address beyond the array
        axi_read(32'h0001_0000, 0, 8'h12, -1, 0);

        // Randomized traffic against the reference memory
        for (int t = 0; t < 40; t++) begin
            addr = $urandom & 32'h0001_FFFC;
            if ($urandom_range(4) == 0) addr = 32'h0000_FFF0 | ($urandom & 32'hC);
            len = int'($urandom_range(15));
            if ($urandom_range(1) == 0) begin
                axi_read(addr, len, 8'($urandom), int'($urandom_range(len)), int'($urandom_range(3)));
            end else begin
                for (int b = 0; b < 16; b++) begin wdat[b] = $urandom; wstb[b] = 4'($urandom_range(15)); end
                wl = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : len;
                axi_write(addr, len, 8'($urandom), wl, 16, int'($urandom_range(2)));
            end
        end

        // Whole-array image against the reference memory
        nbad = 0;
        for (int i = 0; i < NWORDS; i++) if (sram[i] !== ref_mem[i]) nbad++;
        check("mem_image_mismatches", 32'(nbad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
